// File: rtl/regfile_write_arbiter_pkg.sv
// rtl/regfile_write_arbiter_pkg.sv - shared CPU register-file types and constants
package regfile_write_arbiter_pkg;

  localparam int REG_ADDR_W = 5;
  localparam int DATA_W     = 32;
  localparam int NUM_REGS   = 32;

  localparam logic [REG_ADDR_W-1:0] ZERO_REG = '0;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [DATA_W-1:0]     data;
  } wb_entry_t;

  function automatic logic is_zero_reg(input logic [REG_ADDR_W-1:0] a);
    return a == ZERO_REG;
  endfunction

endpackage

// File: rtl/regfile_write_arbiter_wbq_fifo.sv
// rtl/regfile_write_arbiter_wbq_fifo.sv - writeback entry FIFO for multi-cycle results
module wbq_fifo
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push,
  input  wb_entry_t                push_entry,
  input  logic                     pop,
  output wb_entry_t                pop_entry,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     full,
  output logic                     empty
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  assign pop_entry = mem[rd_ptr];

  // DEPTH is a power of two, so pointers wrap by natural overflow
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_entry;
  end

endmodule

// File: rtl/regfile_write_arbiter.sv
// rtl/regfile_write_arbiter.sv - register-file write port arbiter; RFWA_SCOREBOARD_EN builds the pending scoreboard
module regfile_write_arbiter
  import regfile_write_arbiter_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  wb_valid,
  input  logic [REG_ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0]     wb_data,
  input  logic                  md_valid,
  output logic                  md_ready,
  input  logic [REG_ADDR_W-1:0] md_addr,
  input  logic [DATA_W-1:0]     md_data,
  input  logic                  issue_valid,
  input  logic [REG_ADDR_W-1:0] issue_addr,
  output logic                  rf_write,
  output logic [REG_ADDR_W-1:0] rf_addr,
  output logic [DATA_W-1:0]     rf_data,
  output logic [NUM_REGS-1:0]   pending,
  output logic [$clog2(DEPTH):0] count
);

  wb_entry_t head;
  logic      fifo_full;
  logic      fifo_empty;
  logic      deq;

  assign md_ready = !reset && !fifo_full;
  assign deq      = !wb_valid && !fifo_empty;

  wbq_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk        (clk),
    .reset      (reset),
    .push       (md_valid && md_ready),
    .push_entry ('{addr: md_addr, data: md_data}),
    .pop        (deq),
    .pop_entry  (head),
    .count      (count),
    .full       (fifo_full),
    .empty      (fifo_empty)
  );

  // Pipeline writeback has fixed priority; r0 selections leave the port idle
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rf_write <= 1'b0;
      rf_addr  <= '0;
      rf_data  <= '0;
    end else if (wb_valid) begin
      rf_write <= !is_zero_reg(wb_addr);
      rf_addr  <= wb_addr;
      rf_data  <= wb_data;
    end else if (deq) begin
      rf_write <= !is_zero_reg(head.addr);
      rf_addr  <= head.addr;
      rf_data  <= head.data;
    end else begin
      rf_write <= 1'b0;
    end
  end

`ifdef RFWA_SCOREBOARD_EN
  logic [NUM_REGS-1:0] pend_q;
  logic [NUM_REGS-1:0] pend_next;

  // Clear first so a same-edge issue to the same register wins
  always_comb begin
    pend_next = pend_q;
    if (deq) pend_next[head.addr] = 1'b0;
    if (issue_valid) pend_next[issue_addr] = 1'b1;
    pend_next[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) pend_q <= '0;
    else       pend_q <= pend_next;
  end

  assign pending = pend_q;
`else
  logic unused_issue;
  assign unused_issue = ^{issue_valid, issue_addr};
  assign pending      = '0;
`endif

endmodule

// File: tb/tb_regfile_write_arbiter.sv
// tb/tb_regfile_write_arbiter.sv - randomized and directed bench with a queue-based reference model
module tb_regfile_write_arbiter;

  localparam int DEPTH = 4;
`ifdef RFWA_SCOREBOARD_EN
  localparam bit SB = 1'b1;
`else
  localparam bit SB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        md_valid;
  logic        md_ready;
  logic [4:0]  md_addr;
  logic [31:0] md_data;
  logic        issue_valid;
  logic [4:0]  issue_addr;
  logic        rf_write;
  logic [4:0]  rf_addr;
  logic [31:0] rf_data;
  logic [31:0] pending;
  logic [2:0]  count;

  regfile_write_arbiter #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .reset       (reset),
    .wb_valid    (wb_valid),
    .wb_addr     (wb_addr),
    .wb_data     (wb_data),
    .md_valid    (md_valid),
    .md_ready    (md_ready),
    .md_addr     (md_addr),
    .md_data     (md_data),
    .issue_valid (issue_valid),
    .issue_addr  (issue_addr),
    .rf_write    (rf_write),
    .rf_addr     (rf_addr),
    .rf_data     (rf_data),
    .pending     (pending),
    .count       (count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [4:0]  a;
    logic [31:0] d;
  } ent_t;

  ent_t        q[$];
  logic [31:0] exp_pend;
  int          total = 0;
  int          bad = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input logic wv, input logic [4:0] wa, input logic [31:0] wd,
                       input logic mv, input logic [4:0] ma, input logic [31:0] md,
                       input logic iv, input logic [4:0] ia);
    wb_valid = wv; wb_addr = wa; wb_data = wd;
    md_valid = mv; md_addr = ma; md_data = md;
    issue_valid = iv; issue_addr = ia;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
  endtask

  // One clock edge: predict from the current model state and inputs, then compare
  task automatic step();
    logic        exp_ready;
    logic        ew;
    logic [4:0]  ea;
    logic [31:0] ed;
    ent_t        h;
    ent_t        n;
    @(negedge clk);
    exp_ready = (q.size() < DEPTH);
    check("md_ready", 32'(md_ready), 32'(exp_ready));
    ew = 1'b0; ea = '0; ed = '0;
    if (wb_valid) begin
      ew = (wb_addr != 5'd0); ea = wb_addr; ed = wb_data;
    end else if (q.size() > 0) begin
      h = q.pop_front();
      ew = (h.a != 5'd0); ea = h.a; ed = h.d;
      exp_pend[h.a] = 1'b0;
    end
    if (md_valid && exp_ready) begin
      n.a = md_addr; n.d = md_data;
      q.push_back(n);
    end
    if (issue_valid && issue_addr != 5'd0) exp_pend[issue_addr] = 1'b1;
    @(posedge clk);
    #1;
    check("rf_write", 32'(rf_write), 32'(ew));
    if (ew) begin
      check("rf_addr", 32'(rf_addr), 32'(ea));
      check("rf_data", rf_data, ed);
    end
    check("count", 32'(count), 32'(q.size()));
    check("pending", pending, SB ? exp_pend : 32'd0);
  endtask

  initial begin
    logic [4:0] ia;
    exp_pend = '0;
    reset = 1'b1;
    idle();
    #12;
    check("rst_write", 32'(rf_write), 32'd0);
    check("rst_addr", 32'(rf_addr), 32'd0);
    check("rst_data", rf_data, 32'd0);
    check("rst_count", 32'(count), 32'd0);
    check("rst_pending", pending, 32'd0);
    check("rst_ready", 32'(md_ready), 32'd0);
    #5;
    reset = 1'b0;

    // wb only
    drive(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0);
    step();
    check("t1_data", rf_data, 32'hDEADBEEF);
    idle(); step();

    // contention
    drive(1'b1, 5'd1, 32'h11, 1'b1, 5'd7, 32'h1234, 1'b0, 5'd0); step();
    drive(1'b1, 5'd2, 32'h22, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    drive(1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    idle(); step();
    check("t2_md_addr", 32'(rf_addr), 32'd7);
    step();

    // full
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 5'd1, 32'(i), 1'b1, 5'(10 + i), 32'h100 + 32'(i), 1'b0, 5'd0);
      step();
    end
    drive(1'b1, 5'd1, 32'h55, 1'b1, 5'd14, 32'h114, 1'b0, 5'd0); step();
    check("t3_full_ready", 32'(md_ready), 32'd0);
    check("t3_full_count", 32'(count), 32'd4);
    idle();
    for (int i = 0; i < 4; i++) step();
    check("t3_last", 32'(rf_addr), 32'd13);
    step();

    // register 0
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'hABCD, 1'b0, 5'd0); step();
    idle(); step();
    drive(1'b1, 5'd0, 32'h77, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0); step();
    idle(); step();

    // scoreboard: set, clear, and set-wins on same edge
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9); step();
    check("t5_set", 32'(pending[9]), 32'(SB));
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h99, 1'b0, 5'd0); step();
    drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd9); step();
    check("t5_setwins", 32'(pending[9]), 32'(SB));
    drive(1'b0, 5'd0, 32'd0, 1'b1, 5'd9, 32'h999, 1'b0, 5'd0); step();
    idle(); step();
    check("t5_clear", 32'(pending[9]), 32'd0);

    // reset mid-operation
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd21, 32'h21, 1'b1, 5'd4); step();
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd22, 32'h22, 1'b0, 5'd0); step();
    drive(1'b1, 5'd20, 32'h20, 1'b1, 5'd23, 32'h23, 1'b0, 5'd0); step();
    #2;
    reset = 1'b1;
    #1;
    check("t6_count", 32'(count), 32'd0);
    check("t6_pending", pending, 32'd0);
    check("t6_write", 32'(rf_write), 32'd0);
    check("t6_ready", 32'(md_ready), 32'd0);
    q.delete();
    exp_pend = '0;
    idle();
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 4; i++) step();

    // randomized traffic
    for (int i = 0; i < 400; i++) begin
      ia = 5'($urandom_range(0, 31));
      drive(($urandom % 2) == 0, 5'($urandom), $urandom,
            ($urandom % 3) != 0, 5'($urandom), $urandom,
            (($urandom % 4) == 0) && !exp_pend[ia], ia);
      step();
    end
    idle();
    for (int i = 0; i < 8; i++) step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
